uart_tx_fifo_sequencer: RTL and testbench
=========================================

Name: uart_tx_fifo_sequencer

Overview:
- Drains the 128x8 transmit FIFO into the UART transmit shifter.
- Issues single-cycle active-low read strobes to the FIFO and waits out the FIFO's registered read latency.
- Holds the fetched byte, then hands it to the transmitter with a one-cycle load strobe when the shifter is idle.
- Sits between fifo_ctrl (TX instance) and the TX shift register; prefetches the next byte while the current one shifts.

Parameters:
- DATA_WIDTH, 8, FIFO/transmitter data width.
- RD_LATENCY, 2, clock edges from read_n low to valid fifo_data (legal 1..4).
- CNT_WIDTH, 16, width of the transmitted-byte counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  permits new FIFO reads.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO data_out.
- fifo_read_n  out  1  FIFO read strobe, active low.
- tx_busy  in  1  transmitter shifting.
- tx_data  out  DATA_WIDTH  byte presented to transmitter.
- tx_load  out  1  one-cycle load strobe.
- seq_busy  out  1  a byte is in flight (state != IDLE).
- count_clr  in  1  synchronous clear of byte_count.
- byte_count  out  CNT_WIDTH  bytes delivered, saturating.

Behaviour:
- Reset values: fifo_read_n=1, tx_data=0, tx_load=0, seq_busy=0, byte_count=0, state=IDLE, latency counter=0, guard=0.
- State machine:
  - IDLE: if enable && !fifo_empty -> READ; else stay.
  - READ: fifo_read_n=0 for exactly this cycle; load lat_cnt=RD_LATENCY-1 -> WAIT.
  - WAIT: decrement lat_cnt; at the edge where lat_cnt==0, register fifo_data into hold_reg -> HOLD.
  - With RD_LATENCY=1, WAIT lasts one cycle.
  - HOLD: if !tx_busy && !guard -> tx_load=1 and tx_data=hold_reg (registered, same cycle), -> IDLE; else stay.
- Read strobe timing: fifo_read_n is asserted for exactly one cycle per byte. It is never re-asserted before HOLD->IDLE, so a stale fifo_empty (updated one edge after the read) cannot cause a double read.
- Latency: fifo_read_n low at cycle N -> data captured at edge N+RD_LATENCY -> earliest tx_load in cycle N+RD_LATENCY+1.
- Overlap: bytes are delivered back-to-back. The next byte is fetched during shifting and waits in HOLD until tx_busy falls.
- guard: set the cycle tx_load=1, cleared the following cycle. It masks the one-cycle delay before the transmitter raises tx_busy.
- tx_data holds its value until the next tx_load.
- enable deasserted mid-operation: no new READ is issued; a byte already in READ/WAIT/HOLD is still delivered.
- fifo_empty while in HOLD: no effect.
- byte_count:
  - +1 on tx_load; saturates at all-ones.
  - count_clr alone -> 0.
  - count_clr and tx_load in the same cycle -> 1.
- Asynchronous reset in any state returns to IDLE immediately. An in-flight byte is discarded and no tx_load is generated.
- Illegal state encodings recover to IDLE.

Optional Feature:
- Macro: UART_TX_SEQ_CTS_EN.
- Defined: adds input cts_n (1 bit, active low, already synchronised upstream).
  - IDLE->READ additionally requires cts_n==0.
  - HOLD->load additionally requires cts_n==0.
  - cts_n high never truncates a tx_load already issued.
- Undefined: port absent; behaviour as above.

Decomposition:
- Shared package uart_tx_seq_pkg:
  - state encoding constants (IDLE=2'd0, READ=2'd1, WAIT=2'd2, HOLD=2'd3);
  - RD_LATENCY legal range constants;
  - latency counter width (2 bits).
- Sub-module uart_tx_seq_byte_cnt: saturating CNT_WIDTH counter with sync clear, increment, and clear+increment priority.
- Remaining FSM/datapath in the top module.

Test Plan:
- Reset, then FIFO holding 0xA5, enable=1, tx_busy=0 -> fifo_read_n low one cycle at N; tx_load=1 with tx_data=0xA5 at N+3 (RD_LATENCY=2); byte_count=1.
- FIFO holding 0x11,0x22,0x33; tx_busy high 10 cycles after each load -> exactly 3 read strobes; loads in order 0x11,0x22,0x33; each load occurs in the first cycle tx_busy is low; byte_count=3.
- enable dropped the cycle after fifo_read_n low -> byte still loaded; no further reads while enable=0 even with FIFO non-empty.
- reset_n pulsed low while in HOLD -> outputs at reset values asynchronously; no tx_load afterward until a new read.
- byte_count preloaded to 0xFFFF via 65535 loads (or forced) -> further loads keep 0xFFFF; count_clr with tx_load in the same cycle -> 1.
- With UART_TX_SEQ_CTS_EN, cts_n=1 and FIFO non-empty -> no read for 20 cycles; cts_n=0 -> read issued next cycle, load follows per latency.

Source files
------------

// File: rtl/uart_tx_seq_pkg.sv
// rtl/uart_tx_seq_pkg.sv - shared state encoding and latency constants for the UART TX FIFO sequencer
package uart_tx_seq_pkg;

    localparam int LAT_W      = 2;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } seq_state_e;

endpackage

// File: rtl/uart_tx_seq_byte_cnt.sv
// rtl/uart_tx_seq_byte_cnt.sv - saturating delivered-byte counter with synchronous clear
module uart_tx_seq_byte_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A clear coinciding with a delivery still counts that delivery.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? CNT_WIDTH'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo_sequencer.sv
// rtl/uart_tx_fifo_sequencer.sv - drains the TX FIFO into the UART shifter; UART_TX_SEQ_CTS_EN adds cts_n flow control
module uart_tx_fifo_sequencer
    import uart_tx_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read_n,
    input  logic                  tx_busy,
`ifdef UART_TX_SEQ_CTS_EN
    input  logic                  cts_n,
`endif
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_load,
    output logic                  seq_busy,
    input  logic                  count_clr,
    output logic [CNT_WIDTH-1:0]  byte_count
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

    generate
        if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_rd_latency
            rd_latency_out_of_range u_rd_latency_out_of_range ();
        end
    endgenerate

    seq_state_e            state_q, state_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  read_n_q, read_n_d;
    logic                  guard_q, guard_d;
    logic                  cts_ok;
    logic                  load;

`ifdef UART_TX_SEQ_CTS_EN
    assign cts_ok = ~cts_n;
`else
    assign cts_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            hold_q    <= '0;
            tx_data_q <= '0;
            read_n_q  <= 1'b1;
            guard_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            hold_q    <= hold_d;
            tx_data_q <= tx_data_d;
            read_n_q  <= read_n_d;
            guard_q   <= guard_d;
        end
    end

    // No new read until HOLD hands off, so a stale fifo_empty can never double-read.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: if (enable && !fifo_empty && cts_ok) state_d = ST_READ;
            ST_READ: begin
                lat_d   = LAT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    hold_d  = fifo_data;
                    state_d = ST_HOLD;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_HOLD: if (load) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // guard covers the cycle before the shifter reports busy after a load.
    always_comb begin
        load      = (state_q == ST_HOLD) && !tx_busy && !guard_q && cts_ok;
        read_n_d  = (state_d != ST_READ);
        guard_d   = load;
        tx_data_d = load ? hold_q : tx_data_q;
    end

    assign fifo_read_n = read_n_q;
    assign tx_load     = load;
    assign tx_data     = tx_data_d;
    assign seq_busy    = (state_q != ST_IDLE);

    uart_tx_seq_byte_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_byte_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (count_clr),
        .inc     (load),
        .count   (byte_count)
    );

endmodule

// File: tb/tb_uart_tx_fifo_sequencer.sv
// tb/tb_uart_tx_fifo_sequencer.sv - scoreboard bench for uart_tx_fifo_sequencer with FIFO and shifter models
module tb_uart_tx_fifo_sequencer;

    localparam int DW   = 8;
    localparam int RD   = 2;
    localparam int CW   = 16;
    localparam int CW_S = 4;

    logic          clock = 1'b0;
    logic          reset_n, enable, fifo_empty, tx_busy, count_clr;
    logic [DW-1:0] fifo_data;
    logic          fifo_read_n, tx_load, seq_busy;
    logic [DW-1:0] tx_data;
    logic [CW-1:0] byte_count;
    logic          s_read_n, s_tx_load, s_seq_busy;
    logic [DW-1:0] s_tx_data;
    logic [CW_S-1:0] s_count;
`ifdef UART_TX_SEQ_CTS_EN
    logic          cts_n;
`endif

    always #5 clock = ~clock;

    uart_tx_fifo_sequencer #(.DATA_WIDTH(DW), .RD_LATENCY(RD), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_read_n(fifo_read_n), .tx_busy(tx_busy),
`ifdef UART_TX_SEQ_CTS_EN
        .cts_n(cts_n),
`endif
        .tx_data(tx_data), .tx_load(tx_load), .seq_busy(seq_busy),
        .count_clr(count_clr), .byte_count(byte_count)
    );

    // Narrow-counter twin sees identical stimulus so saturation is reachable quickly.
    uart_tx_fifo_sequencer #(.DATA_WIDTH(DW), .RD_LATENCY(RD), .CNT_WIDTH(CW_S)) dut_small (
        .clock(clock), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_read_n(s_read_n), .tx_busy(tx_busy),
`ifdef UART_TX_SEQ_CTS_EN
        .cts_n(cts_n),
`endif
        .tx_data(s_tx_data), .tx_load(s_tx_load), .seq_busy(s_seq_busy),
        .count_clr(count_clr), .byte_count(s_count)
    );

    typedef struct { logic [7:0] data; int cyc; } item_t;

    int         n_tests = 0, n_fail = 0;
    int         cyc = 0;
    logic [7:0] fifo_q[$];
    item_t      sched_q[$];
    item_t      exp_q[$];
    int         n_strobes = 0, n_loads = 0, last_strobe_cyc = 0, last_load_cyc = 0;
    int         busy_left = 0, busy_mode = 0, exp_count = 0;
    bit         hold_busy = 0, load_neg = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cts_low();
`ifdef UART_TX_SEQ_CTS_EN
        return cts_n == 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // FIFO with RD-edge registered read latency and one-edge-late empty flag, plus shifter model.
    always @(posedge clock) begin
        #1;
        if (!reset_n) begin
            busy_left = 0;
            sched_q.delete();
        end
        fifo_empty = (fifo_q.size() == 0);
        if (sched_q.size() > 0 && sched_q[0].cyc == cyc) begin
            fifo_data = sched_q[0].data;
            void'(sched_q.pop_front());
        end else begin
            fifo_data = 8'($urandom);
        end
        if (fifo_read_n === 1'b0) begin
            n_strobes++;
            last_strobe_cyc = cyc;
            check("strobe_enable", enable, 1);
            check("strobe_cts", cts_low(), 1);
            check("strobe_no_overlap", exp_q.size(), 0);
            check("strobe_nonempty", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) begin
                item_t it;
                it.data = fifo_q.pop_front();
                it.cyc  = cyc + RD;
                sched_q.push_back(it);
                it.cyc  = cyc + RD + 1;
                exp_q.push_back(it);
            end
        end
        if (load_neg) busy_left = (busy_mode < 0) ? $urandom_range(0, 12) : busy_mode;
        else if (busy_left > 0) busy_left--;
        tx_busy = (busy_left > 0) || hold_busy;
    end

    // Monitor: every load must carry the oldest fetched byte, no earlier than its data
    // is available and no later than the first cycle the shifter is free.
    always @(negedge clock) begin
        load_neg = (tx_load === 1'b1);
        if (reset_n === 1'b1) begin
            if (exp_q.size() > 0 && cyc >= exp_q[0].cyc && tx_busy === 1'b0 && cts_low())
                check("load_on_time", tx_load, 1);
            if (tx_load === 1'b1) begin
                n_loads++;
                last_load_cyc = cyc;
                check("load_has_byte", exp_q.size() > 0, 1);
                check("small_tracks_main", {s_read_n, s_tx_load, s_tx_data, s_seq_busy},
                      {fifo_read_n, tx_load, tx_data, seq_busy});
                if (exp_q.size() > 0) begin
                    item_t e;
                    e = exp_q.pop_front();
                    check("load_data", tx_data, e.data);
                    check("load_not_early", cyc >= e.cyc, 1);
                    check("load_busy_low", tx_busy, 0);
                end
            end
        end
    end

    task automatic check_counts(input string name);
        check(name, byte_count, (exp_count > 65535) ? 65535 : exp_count);
        check({name, "_small"}, s_count, (exp_count > 15) ? 15 : exp_count);
    endtask

    task automatic wait_drain(input int max);
        int k = 0;
        while (k < max && !(fifo_q.size() == 0 && exp_q.size() == 0 && seq_busy === 1'b0)) begin
            @(negedge clock);
            k++;
        end
        check("drain_in_time", k < max, 1);
    endtask

    task automatic wait_strobe(input int max);
        int k = 0;
        while (k < max && fifo_read_n !== 1'b0) begin
            @(negedge clock);
            k++;
        end
        check("strobe_in_time", k < max, 1);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_count++;
    endtask

    int s0, l0;

    initial begin
        reset_n = 1'b0; enable = 1'b0; count_clr = 1'b0; tx_busy = 1'b0;
        fifo_empty = 1'b1; fifo_data = '0;
`ifdef UART_TX_SEQ_CTS_EN
        cts_n = 1'b0;
`endif
        repeat (3) @(negedge clock);
        check("rst_read_n", fifo_read_n, 1);
        check("rst_tx_load", tx_load, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_byte_count", byte_count, 0);
        reset_n = 1'b1;

        // Single byte, idle shifter: load exactly RD+1 cycles after the strobe.
        @(negedge clock);
        busy_mode = 0;
        push(8'hA5);
        enable = 1'b1;
        wait_drain(50);
        check("single_latency", last_load_cyc - last_strobe_cyc, RD + 1);
        check("single_strobes", n_strobes, 1);
        check_counts("single_count");

        count_clr = 1'b1;
        @(negedge clock);
        count_clr = 1'b0;
        exp_count = 0;
        check_counts("clr_alone");

        // Three bytes with a 10-cycle busy shifter.
        busy_mode = 10;
        s0 = n_strobes;
        push(8'h11); push(8'h22); push(8'h33);
        wait_drain(200);
        check("three_strobes", n_strobes - s0, 3);
        check_counts("three_count");

        // enable dropped right after a strobe: that byte still goes, nothing else is read.
        busy_mode = 0;
        s0 = n_strobes; l0 = n_loads;
        push(8'h5A); push(8'hC3);
        wait_strobe(20);
        enable = 1'b0;
        repeat (20) @(negedge clock);
        check("en_drop_loads", n_loads - l0, 1);
        check("en_drop_strobes", n_strobes - s0, 1);
        check("en_drop_fifo_left", fifo_q.size(), 1);
        enable = 1'b1;
        wait_drain(50);
        check_counts("en_drop_count");

        // Reset while a byte waits in HOLD: outputs drop at once and the byte is lost.
        hold_busy = 1;
        push(8'h77);
        wait_strobe(20);
        repeat (RD + 1) @(negedge clock);
        check("hold_seq_busy", seq_busy, 1);
        l0 = n_loads;
        reset_n = 1'b0;
        #1;
        check("async_rst_read_n", fifo_read_n, 1);
        check("async_rst_tx_load", tx_load, 0);
        check("async_rst_tx_data", tx_data, 0);
        check("async_rst_seq_busy", seq_busy, 0);
        check("async_rst_count", byte_count, 0);
        exp_q.delete();
        exp_count = 0;
        @(negedge clock);
        reset_n = 1'b1;
        hold_busy = 0;
        repeat (15) @(negedge clock);
        check("post_rst_no_load", n_loads - l0, 0);

        // Random bursts with random enable and random shifter busy time.
        busy_mode = -1;
        for (int it = 0; it < 30; it++) begin
            int nb;
            nb = $urandom_range(1, 5);
            for (int j = 0; j < nb; j++) push(8'($urandom));
            for (int j = 0; j < int'($urandom_range(0, 30)); j++) begin
                enable = ($urandom_range(0, 3) != 0);
                @(negedge clock);
            end
        end
        enable = 1'b1;
        wait_drain(2000);
        check_counts("random_count");

        // Clear coinciding with a load leaves the count at one.
        busy_mode = 0;
        push(8'h3C);
        begin
            int k = 0;
            while (k < 30 && tx_load !== 1'b1) begin
                @(negedge clock);
                k++;
            end
            check("clr_load_seen", k < 30, 1);
        end
        count_clr = 1'b1;
        @(negedge clock);
        count_clr = 1'b0;
        exp_count = 1;
        wait_drain(50);
        check_counts("clr_with_load");

`ifdef UART_TX_SEQ_CTS_EN
        cts_n = 1'b1;
        s0 = n_strobes;
        push(8'h99);
        repeat (20) @(negedge clock);
        check("cts_blocks_read", n_strobes - s0, 0);
        cts_n = 1'b0;
        @(negedge clock);
        check("cts_read_next", fifo_read_n, 0);
        wait_drain(50);
        check_counts("cts_count");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
